ft245_sync_bus_arbiter: RTL and testbench

FT245_SYNC_BUS_ARBITER -- requirements
Module: ft245_sync_bus_arbiter

---
 rtl/ft245_sync_bus_arbiter.sv | 149 ++++++++++++++
 tb/tb_ft245_sync_bus_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ft245_sync_bus_arbiter.sv
`default_nettype none
// ============================================================================
// ft245_sync_bus_arbiter
// Half-duplex FT245 synchronous-FIFO bus arbiter with burst-limited fairness.
// Rev 1.0
// ============================================================================
module ft245_sync_bus_arbiter #(
  parameter int BURST_MAX = 64
) (
  input  logic       ftdi_clk,
  input  logic       rst,
  input  logic       ftdi_rde_n,
  input  logic       ftdi_txe_n,
  input  logic [7:0] ftdi_data_i,
  output logic [7:0] ftdi_data_o,
  output logic       ftdi_data_oe,
  output logic       ftdi_oe_n,
  output logic       ftdi_rd_n,
  output logic       ftdi_wr_n,
  output logic       ftdi_siwu,
  output logic [7:0] rx_data,
  output logic       rx_stb,
  input  logic       rx_ready,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ack,
  input  logic       tx_flush,
  output logic       rx_active,
  output logic       tx_active
);

  localparam int CW = $clog2(BURST_MAX + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(BURST_MAX);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RX_OE    = 3'd1,
    RX_READ  = 3'd2,
    RX_END   = 3'd3,
    TX_WRITE = 3'd4,
    TX_END   = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    rx_data_q, rx_data_d;
  logic          rx_stb_q, rx_stb_d;
  logic          flush_pending_q, flush_pending_d;
  logic          rx_limited_q, rx_limited_d;
  logic          rx_elig, tx_elig, below_max, siwu_fire;

  always_ff @(posedge ftdi_clk) begin
    if (rst) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      rx_data_q       <= '0;
      rx_stb_q        <= 1'b0;
      flush_pending_q <= 1'b0;
      rx_limited_q    <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      rx_data_q       <= rx_data_d;
      rx_stb_q        <= rx_stb_d;
      flush_pending_q <= flush_pending_d;
      rx_limited_q    <= rx_limited_d;
    end
  end

  always_comb begin
    rx_elig      = ~ftdi_rde_n & rx_ready;
    tx_elig      = tx_valid & ~ftdi_txe_n;
    below_max    = (cnt_q < CNT_MAX);
    siwu_fire    = 1'b0;
    state_d      = state_q;
    cnt_d        = cnt_q;
    rx_data_d    = rx_data_q;
    rx_stb_d     = 1'b0;
    rx_limited_d = rx_limited_q;
    ftdi_oe_n    = 1'b1;
    ftdi_rd_n    = 1'b1;
    ftdi_wr_n    = 1'b1;
    ftdi_data_oe = 1'b0;

    case (state_q)
      IDLE: begin
        // RX is the default winner; TX only pre-empts after RX hit its burst cap.
        if (rx_elig && !(tx_elig && rx_limited_q)) begin
          state_d      = RX_OE;
          cnt_d        = '0;
          rx_limited_d = 1'b0;
        end else if (tx_elig) begin
          state_d      = TX_WRITE;
          cnt_d        = '0;
          rx_limited_d = 1'b0;
        end else begin
          siwu_fire = flush_pending_q & ~rst;
        end
      end
      RX_OE: begin
        ftdi_oe_n = 1'b0;
        state_d   = RX_READ;
      end
      RX_READ: begin
        ftdi_oe_n = 1'b0;
        // Strobes are gated by rst so nothing moves on the reset edge.
        ftdi_rd_n = ~(rx_elig & below_max & ~rst);
        if (!ftdi_rd_n) begin
          rx_data_d = ftdi_data_i;
          rx_stb_d  = 1'b1;
          cnt_d     = cnt_q + CW'(1);
        end else begin
          state_d      = RX_END;
          rx_limited_d = ~below_max;
        end
      end
      RX_END: begin
        state_d = IDLE;
      end
      TX_WRITE: begin
        ftdi_data_oe = 1'b1;
        ftdi_wr_n    = ~(tx_elig & below_max & ~rst);
        if (!ftdi_wr_n) begin
          cnt_d = cnt_q + CW'(1);
        end else begin
          state_d = TX_END;
        end
      end
      TX_END: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    flush_pending_d = siwu_fire ? 1'b0 : (flush_pending_q | tx_flush);
  end

  assign ftdi_siwu   = ~siwu_fire;
  assign ftdi_data_o = tx_data;
  assign tx_ack      = ~ftdi_wr_n;
  assign rx_data     = rx_data_q;
  assign rx_stb      = rx_stb_q;
  assign rx_active   = (state_q == RX_OE) || (state_q == RX_READ);
  assign tx_active   = (state_q == TX_WRITE);

endmodule
`default_nettype wire

// File: tb/tb_ft245_sync_bus_arbiter.sv
`default_nettype none
// ============================================================================
// tb_ft245_sync_bus_arbiter
// Randomized + directed scoreboard bench with FTDI FIFO and client models.
// Rev 1.0
// ============================================================================
module tb_ft245_sync_bus_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // shared inputs
  logic       rst = 1'b1, rde_n = 1'b1, txe_n = 1'b1, rx_ready = 1'b0;
  logic       tx_valid = 1'b0, tx_flush = 1'b0;
  logic [7:0] data_i = 8'h00, tx_data = 8'h00;

  // per-instance outputs: [0] BURST_MAX=8, [1] BURST_MAX=4
  logic [1:0][7:0] data_o_v, rx_data_v;
  logic [1:0] doe_v, oe_n_v, rd_n_v, wr_n_v, siwu_v, rx_stb_v, tx_ack_v, rxa_v, txa_v;

  ft245_sync_bus_arbiter #(.BURST_MAX(8)) u_dut_a (
    .ftdi_clk(clk), .rst(rst), .ftdi_rde_n(rde_n), .ftdi_txe_n(txe_n),
    .ftdi_data_i(data_i), .ftdi_data_o(data_o_v[0]), .ftdi_data_oe(doe_v[0]),
    .ftdi_oe_n(oe_n_v[0]), .ftdi_rd_n(rd_n_v[0]), .ftdi_wr_n(wr_n_v[0]),
    .ftdi_siwu(siwu_v[0]), .rx_data(rx_data_v[0]), .rx_stb(rx_stb_v[0]),
    .rx_ready(rx_ready), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ack(tx_ack_v[0]), .tx_flush(tx_flush), .rx_active(rxa_v[0]),
    .tx_active(txa_v[0]));

  ft245_sync_bus_arbiter #(.BURST_MAX(4)) u_dut_b (
    .ftdi_clk(clk), .rst(rst), .ftdi_rde_n(rde_n), .ftdi_txe_n(txe_n),
    .ftdi_data_i(data_i), .ftdi_data_o(data_o_v[1]), .ftdi_data_oe(doe_v[1]),
    .ftdi_oe_n(oe_n_v[1]), .ftdi_rd_n(rd_n_v[1]), .ftdi_wr_n(wr_n_v[1]),
    .ftdi_siwu(siwu_v[1]), .rx_data(rx_data_v[1]), .rx_stb(rx_stb_v[1]),
    .rx_ready(rx_ready), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ack(tx_ack_v[1]), .tx_flush(tx_flush), .rx_active(rxa_v[1]),
    .tx_active(txa_v[1]));

  logic sel = 1'b0;
  logic [7:0] data_o, rx_data;
  logic data_oe, oe_n, rd_n, wr_n, siwu, rx_stb, tx_ack, rx_active, tx_active;
  assign data_o    = data_o_v[sel];
  assign rx_data   = rx_data_v[sel];
  assign data_oe   = doe_v[sel];
  assign oe_n      = oe_n_v[sel];
  assign rd_n      = rd_n_v[sel];
  assign wr_n      = wr_n_v[sel];
  assign siwu      = siwu_v[sel];
  assign rx_stb    = rx_stb_v[sel];
  assign tx_ack    = tx_ack_v[sel];
  assign rx_active = rxa_v[sel];
  assign tx_active = txa_v[sel];

  // ---------------- models, scoreboard and control ----------------
  logic [7:0] ftdi_rx[$];   // bytes the FTDI holds for the host-side reader
  logic [7:0] cli_tx[$];    // bytes the client wants to send
  logic [7:0] exp_rx[$];    // expected rx_stb byte order
  logic [7:0] exp_tx[$];    // expected bus write byte order

  typedef struct { bit dir; int n; int lead; int run; } glog_t;
  glog_t glog[$];

  int  n_err = 0, n_checks = 0;
  int  cyc = 0, n_rx_drv = 0, n_wr_drv = 0;
  int  stb_cnt = 0, stb_nr = 0, wr_cnt = 0, siwu_cnt = 0, siwu_gap = -1;
  logic sel_req = 1'b0, rst_req = 1'b1, mon_en = 1'b0, mon_en_req = 1'b0;
  logic rdy = 1'b0, txe_block = 1'b1, tx_en = 1'b0, flush_req = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               nm, act, act, exp, exp, cyc);
    end
  endtask

  // One bus cycle: apply inputs on the falling edge, then let the FTDI and
  // client models react to the strobes that will be sampled on the next rise.
  task automatic step();
    @(negedge clk);
    sel      = sel_req;
    rst      = rst_req;
    mon_en   = mon_en_req;
    rde_n    = (ftdi_rx.size() == 0);
    data_i   = rde_n ? 8'h00 : ftdi_rx[0];
    tx_valid = tx_en && (cli_tx.size() != 0);
    tx_data  = tx_valid ? cli_tx[0] : 8'h00;
    txe_n    = txe_block;
    rx_ready = rdy;
    tx_flush = flush_req;
    flush_req = 1'b0;
    #2;
    if (!rd_n && !rde_n) begin void'(ftdi_rx.pop_front()); n_rx_drv++; end
    if (!wr_n) n_wr_drv++;
    if (tx_ack && tx_valid) void'(cli_tx.pop_front());
  endtask

  task automatic clr_stats();
    glog.delete();
    stb_cnt = 0; stb_nr = 0; wr_cnt = 0; siwu_cnt = 0; siwu_gap = -1;
    n_rx_drv = 0; n_wr_drv = 0;
  endtask

  task automatic do_reset(input logic s);
    mon_en_req = 1'b0; rst_req = 1'b1; sel_req = s;
    rdy = 1'b0; txe_block = 1'b1; tx_en = 1'b0;
    repeat (3) step();
    rst_req = 1'b0; mon_en_req = 1'b1;
    clr_stats();
  endtask

  task automatic load_rx(input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) begin
      ftdi_rx.push_back(base + 8'(i));
      exp_rx.push_back(base + 8'(i));
    end
  endtask

  task automatic load_tx(input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) begin
      cli_tx.push_back(base + 8'(i));
      exp_tx.push_back(base + 8'(i));
    end
  endtask

  task automatic run_until_idle(input int budget, input string nm);
    int k;
    rdy = 1'b1; txe_block = 1'b0; tx_en = 1'b1;
    k = 0;
    while ((ftdi_rx.size() != 0 || cli_tx.size() != 0 || exp_rx.size() != 0 ||
            exp_tx.size() != 0 || rx_active || tx_active) && k < budget) begin
      step(); k++;
    end
    if (k >= budget) chk({nm, "_timeout"}, 1, 0);
    repeat (3) step();
  endtask

  // ---------------- monitor: scoreboard pops + protocol ----------------
  logic prev_doe = 0, prev_oe = 0, prev_siwu_low = 0, prev_rxa = 0, prev_txa = 0;
  int   rx_n = 0, rx_lead = 0, rx_run = 0, rx_cur = 0, tx_n = 0, tx_run = 0, tx_cur = 0;
  int   rx_last_fall = 0;

  always @(negedge clk) begin : mon
    logic bad;
    logic [7:0] e;
    int bm;
    #3;
    cyc++;
    if (!mon_en) begin
      prev_doe = 0; prev_oe = 0; prev_siwu_low = 0; prev_rxa = 0; prev_txa = 0;
      rx_n = 0; rx_lead = 0; rx_run = 0; rx_cur = 0; tx_n = 0; tx_run = 0; tx_cur = 0;
    end else begin
      bm = sel ? 4 : 8;
      if (rx_stb) begin
        if (exp_rx.size() == 0) chk("rx_unexpected_stb", 1, 0);
        else begin e = exp_rx.pop_front(); chk("rx_data", rx_data, e); end
        stb_cnt++;
        if (!rx_ready) stb_nr++;
      end
      if (!wr_n) begin
        if (exp_tx.size() == 0) chk("tx_unexpected_write", 1, 0);
        else begin e = exp_tx.pop_front(); chk("tx_bus_byte", data_o, e); end
        wr_cnt++;
      end
      bad = 1'b0;
      if (data_oe && !oe_n) bad = 1'b1;
      if ((!oe_n && prev_doe) || (data_oe && prev_oe)) bad = 1'b1;
      if (!rd_n && (oe_n || !rx_ready || rde_n)) bad = 1'b1;
      if (!wr_n && (!data_oe || !tx_valid || txe_n)) bad = 1'b1;
      if (tx_ack != !wr_n) bad = 1'b1;
      if (rst && (!rd_n || !wr_n)) bad = 1'b1;
      if (rx_active != !oe_n || tx_active != data_oe) bad = 1'b1;
      if (!siwu && (prev_siwu_low || !oe_n || !rd_n || !wr_n || data_oe)) bad = 1'b1;
      chk("protocol", bad, 0);

      if (!rd_n) begin rx_n++; rx_cur++; if (rx_cur > rx_run) rx_run = rx_cur; end
      else rx_cur = 0;
      if (rx_active && rd_n && rx_n == 0) rx_lead++;
      if (!wr_n) begin tx_n++; tx_cur++; if (tx_cur > tx_run) tx_run = tx_cur; end
      else tx_cur = 0;
      if (prev_rxa && !rx_active) begin
        chk("rx_burst_within_max", int'(rx_n <= bm), 1);
        glog.push_back('{1'b0, rx_n, rx_lead, rx_run});
        rx_n = 0; rx_lead = 0; rx_run = 0; rx_last_fall = cyc;
      end
      if (prev_txa && !tx_active) begin
        chk("tx_burst_within_max", int'(tx_n <= bm), 1);
        glog.push_back('{1'b1, tx_n, 0, tx_run});
        tx_n = 0; tx_run = 0;
      end
      if (!siwu) begin siwu_cnt++; siwu_gap = cyc - rx_last_fall; end
      prev_doe = data_oe; prev_oe = !oe_n; prev_siwu_low = !siwu;
      prev_rxa = rx_active; prev_txa = tx_active;
    end
  end

  task automatic rand_phase(input logic s, input int ncyc);
    logic [7:0] b;
    do_reset(s);
    for (int i = 0; i < ncyc; i++) begin
      if ($urandom_range(9) < 3 && ftdi_rx.size() < 16) begin
        b = 8'($urandom); ftdi_rx.push_back(b); exp_rx.push_back(b);
      end
      if ($urandom_range(9) < 3 && cli_tx.size() < 16) begin
        b = 8'($urandom); cli_tx.push_back(b); exp_tx.push_back(b);
      end
      rdy       = ($urandom_range(3) != 0);
      txe_block = ($urandom_range(4) == 0);
      tx_en     = ($urandom_range(5) != 0);
      if ($urandom_range(31) == 0) flush_req = 1'b1;
      step();
    end
    run_until_idle(600, "rand_drain");
    chk("rand_rx_all_delivered", exp_rx.size(), 0);
    chk("rand_tx_all_sent", exp_tx.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    // reset state
    do_reset(1'b0);
    step();
    chk("reset_strobes", {oe_n, rd_n, wr_n, siwu}, 4'hF);
    chk("reset_data_oe", data_oe, 0);
    chk("reset_rx_stb", rx_stb, 0);
    chk("reset_rx_data", rx_data, 0);
    chk("reset_tx_ack", tx_ack, 0);
    chk("reset_active", {rx_active, tx_active}, 0);

    // five-byte read
    clr_stats();
    load_rx(5, 8'h11);
    run_until_idle(60, "rx5");
    chk("rx5_grants", glog.size(), 1);
    if (glog.size() >= 1) begin
      chk("rx5_dir", glog[0].dir, 0);
      chk("rx5_bytes", glog[0].n, 5);
      chk("rx5_oe_only_lead", glog[0].lead, 1);
      chk("rx5_rd_run", glog[0].run, 5);
    end
    chk("rx5_stb_count", stb_cnt, 5);

    // txe_n rises after byte 3 of 6
    clr_stats();
    load_tx(6, 8'hA0);
    rdy = 1'b0; txe_block = 1'b0; tx_en = 1'b1;
    k = 0;
    while (n_wr_drv < 3 && k < 40) begin step(); k++; end
    if (k >= 40) chk("txe_stall_timeout", 1, 0);
    txe_block = 1'b1;
    repeat (5) step();
    chk("txe_stall_acks_held", wr_cnt, 3);
    run_until_idle(60, "txe_stall");
    chk("txe_stall_grants", glog.size(), 2);
    if (glog.size() == 2) begin
      chk("txe_stall_g0", {glog[0].dir, 8'(glog[0].n)}, {1'b1, 8'd3});
      chk("txe_stall_g1", {glog[1].dir, 8'(glog[1].n)}, {1'b1, 8'd3});
    end
    chk("txe_stall_total", wr_cnt, 6);

    // rx_ready drops after byte 3 of 6
    clr_stats();
    load_rx(6, 8'h30);
    rdy = 1'b1; txe_block = 1'b1; tx_en = 1'b0;
    k = 0;
    while (n_rx_drv < 3 && k < 40) begin step(); k++; end
    if (k >= 40) chk("rdy_drop_timeout", 1, 0);
    rdy = 1'b0;
    repeat (4) step();
    chk("rdy_drop_one_skid_stb", stb_nr, 1);
    run_until_idle(60, "rdy_drop");
    chk("rdy_drop_stb_total", stb_cnt, 6);
    chk("rdy_drop_grants", glog.size(), 2);

    // flush during an RX burst
    clr_stats();
    load_rx(5, 8'h41);
    rdy = 1'b1; txe_block = 1'b1; tx_en = 1'b0;
    k = 0;
    while (n_rx_drv < 2 && k < 40) begin step(); k++; end
    flush_req = 1'b1;
    run_until_idle(60, "flush");
    chk("flush_siwu_pulses", siwu_cnt, 1);
    chk("flush_siwu_after_rx_end", siwu_gap, 1);

    // reset mid TX burst; rx_data still holds 0x45 from above
    clr_stats();
    load_tx(6, 8'hC0);
    rdy = 1'b0; txe_block = 1'b0; tx_en = 1'b1;
    k = 0;
    while (n_wr_drv < 2 && k < 40) begin step(); k++; end
    rst_req = 1'b1;
    step();
    chk("rst_cycle_no_write", {wr_n, tx_ack}, 2'b10);
    rst_req = 1'b0;
    step();
    chk("rst_mid_tx_strobes", {oe_n, rd_n, wr_n, siwu}, 4'hF);
    chk("rst_mid_tx_data_oe", data_oe, 0);
    chk("rst_mid_tx_ack", tx_ack, 0);
    chk("rst_mid_tx_idle", {rx_active, tx_active}, 0);
    chk("rst_mid_tx_rx_data", rx_data, 0);
    run_until_idle(60, "rst_mid_tx");
    chk("rst_mid_tx_bytes_sent", wr_cnt, 6);

    // BURST_MAX=4 alternation
    do_reset(1'b1);
    load_rx(12, 8'h50);
    load_tx(8, 8'h90);
    run_until_idle(200, "fair");
    chk("fair_grants", glog.size(), 5);
    for (int i = 0; i < 5 && i < glog.size(); i++) begin
      chk($sformatf("fair_g%0d_dir", i), glog[i].dir, i % 2);
      chk($sformatf("fair_g%0d_len", i), glog[i].n, 4);
    end
    chk("fair_tx_acks", wr_cnt, 8);

    // randomized traffic on both instances
    rand_phase(1'b1, 1500);
    rand_phase(1'b0, 800);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
